// File: rtl/codec_cfg_pkg.sv
// Shared types and constants for the codec configuration sequencer.
// Holds the FSM state enum, frame field widths and WM8731 register addresses.
package codec_cfg_pkg;

   localparam int DEV_ADDR_W = 8;
   localparam int REG_ADDR_W = 7;
   localparam int REG_DATA_W = 9;
   localparam int ENTRY_W    = REG_ADDR_W + REG_DATA_W;
   localparam int FRAME_W    = DEV_ADDR_W + ENTRY_W;
   localparam int CNT_W      = 13;

   typedef enum logic [3:0] {
      S_INIT,
      S_LOAD,
      S_START,
      S_ARM,
      S_WAIT,
      S_CHECK,
      S_GAP,
      S_IDLE,
      S_FAIL
   } state_t;

   typedef enum logic {
      SRC_BOOT,
      SRC_USER
   } src_t;

   localparam logic [REG_ADDR_W-1:0] RA_LLINE  = 7'h00;
   localparam logic [REG_ADDR_W-1:0] RA_RLINE  = 7'h01;
   localparam logic [REG_ADDR_W-1:0] RA_LHP    = 7'h02;
   localparam logic [REG_ADDR_W-1:0] RA_RHP    = 7'h03;
   localparam logic [REG_ADDR_W-1:0] RA_APATH  = 7'h04;
   localparam logic [REG_ADDR_W-1:0] RA_DPATH  = 7'h05;
   localparam logic [REG_ADDR_W-1:0] RA_PWR    = 7'h06;
   localparam logic [REG_ADDR_W-1:0] RA_IFACE  = 7'h07;
   localparam logic [REG_ADDR_W-1:0] RA_SRATE  = 7'h08;
   localparam logic [REG_ADDR_W-1:0] RA_ACTIVE = 7'h09;
   localparam logic [REG_ADDR_W-1:0] RA_RESET  = 7'h0F;

   function automatic logic [ENTRY_W-1:0] reg_entry(
      input logic [REG_ADDR_W-1:0] a,
      input logic [REG_DATA_W-1:0] d
   );
      return {a, d};
   endfunction

endpackage

// File: rtl/codec_reg_rom.sv
// Boot register table for the codec: idx -> {reg_addr[6:0], reg_data[8:0]}.
// Ports: i_idx (4b table index), o_entry (16b register write entry).
module codec_reg_rom
   import codec_cfg_pkg::*;
#(
   parameter int NUM_REGS = 10
) (
   input  logic [3:0]         i_idx,
   output logic [ENTRY_W-1:0] o_entry
);

   localparam logic [3:0] IDX_LAST = 4'(NUM_REGS - 1);

   logic [ENTRY_W-1:0] w_tbl;

   always_comb begin
      w_tbl = '0;
      case (i_idx)
         4'd0:    w_tbl = reg_entry(RA_RESET, 9'h000);
         4'd1:    w_tbl = reg_entry(RA_LLINE, 9'h017);
         4'd2:    w_tbl = reg_entry(RA_LHP,   9'h079);
         4'd3:    w_tbl = reg_entry(RA_APATH, 9'h012);
         4'd4:    w_tbl = reg_entry(RA_DPATH, 9'h000);
         4'd5:    w_tbl = reg_entry(RA_PWR,   9'h000);
         4'd6:    w_tbl = reg_entry(RA_IFACE, 9'h00A);
         4'd7:    w_tbl = reg_entry(RA_SRATE, 9'h000);
         4'd8:    w_tbl = reg_entry(RA_RHP,   9'h079);
         default: w_tbl = '0;
      endcase
   end

   // Activation must always be the final write, whatever the table length.
   always_comb begin
      o_entry = w_tbl;
      if (i_idx == IDX_LAST) o_entry = reg_entry(RA_ACTIVE, 9'h001);
   end

endmodule

// File: rtl/codec_config_sequencer.sv
// Boots the audio codec through i2c_controller, then shares it with runtime writes.
// Ports: clk/reset; i2c_start/i2c_data/i2c_done/i2c_ack to the controller;
// reconfig; wr_req/wr_addr/wr_wdata/wr_ready/wr_fail user port;
// busy, config_done, config_error, err_index status.
module codec_config_sequencer
   import codec_cfg_pkg::*;
#(
   parameter logic [7:0] DEV_ADDR       = 8'h34,
   parameter int         NUM_REGS       = 10,
   parameter int         MAX_RETRY      = 3,
   parameter int         GAP_CYCLES     = 256,
   parameter int         TIMEOUT_CYCLES = 8191
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  i2c_start,
   output logic [FRAME_W-1:0]    i2c_data,
   input  logic                  i2c_done,
   input  logic                  i2c_ack,
   input  logic                  reconfig,
   input  logic                  wr_req,
   input  logic [REG_ADDR_W-1:0] wr_addr,
   input  logic [REG_DATA_W-1:0] wr_wdata,
   output logic                  wr_ready,
   output logic                  wr_fail,
   output logic                  busy,
   output logic                  config_done,
   output logic                  config_error,
   output logic [3:0]            err_index
);

   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [3:0]       IDX_LAST  = 4'(NUM_REGS - 1);
   localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);

   state_t             r_state;
   src_t               r_src;
   logic [3:0]         r_idx;
   logic [1:0]         r_retry;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_ack;
   logic               r_resend;
   logic               r_pend;
   logic               r_start;
   logic [FRAME_W-1:0] r_data;
   logic               r_wr_ready;
   logic               r_wr_fail;
   logic               r_busy;
   logic               r_done;
   logic               r_error;
   logic [3:0]         r_err_idx;

   logic [ENTRY_W-1:0] w_rom;
   logic [CNT_W-1:0]   w_cnt_inc;
   logic               w_restart;

   codec_reg_rom #(
      .NUM_REGS (NUM_REGS)
   ) u_rom (
      .i_idx   (r_idx),
      .o_entry (w_rom)
   );

   assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
   assign w_restart = reconfig | r_pend;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_INIT;
         r_src      <= SRC_BOOT;
         r_idx      <= '0;
         r_retry    <= '0;
         r_cnt      <= '0;
         r_ack      <= 1'b0;
         r_resend   <= 1'b0;
         r_pend     <= 1'b0;
         r_start    <= 1'b0;
         r_data     <= '0;
         r_wr_ready <= 1'b0;
         r_wr_fail  <= 1'b0;
         r_busy     <= 1'b1;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_err_idx  <= '0;
      end else begin
         r_start    <= 1'b0;
         r_wr_ready <= 1'b0;
         r_busy     <= 1'b1;
         // A frame in flight is never abandoned; reconfig waits for IDLE.
         if (reconfig && r_state != S_IDLE && r_state != S_FAIL)
            r_pend <= 1'b1;
         unique case (r_state)
            S_INIT: begin
               // The controller has no reset; let any stale frame drain.
               if (r_cnt >= TMO_LAST) begin
                  r_cnt   <= '0;
                  r_idx   <= '0;
                  r_retry <= '0;
                  r_src   <= SRC_BOOT;
                  r_state <= S_LOAD;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            S_LOAD: begin
               if (r_src == SRC_BOOT)
                  r_data <= {DEV_ADDR, w_rom};
               else
                  r_data <= {DEV_ADDR, wr_addr, wr_wdata};
               r_start <= 1'b1;
               r_state <= S_START;
            end
            S_START: begin
               r_state <= S_ARM;
            end
            S_ARM: begin
               // i2c_done still shows the previous frame here.
               r_cnt   <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (i2c_done) begin
                  r_ack   <= i2c_ack;
                  r_state <= S_CHECK;
               end else if (r_cnt >= TMO_LAST) begin
                  r_ack   <= 1'b0;
                  r_state <= S_CHECK;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            S_CHECK: begin
               r_cnt <= '0;
               if (r_ack) begin
                  r_retry <= '0;
                  if (r_src == SRC_BOOT) begin
                     if (r_idx == IDX_LAST) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                     end else begin
                        r_idx    <= r_idx + 1'b1;
                        r_resend <= 1'b1;
                        r_state  <= S_GAP;
                     end
                  end else begin
                     r_wr_ready <= 1'b1;
                     r_wr_fail  <= 1'b0;
                     r_resend   <= 1'b0;
                     r_state    <= S_GAP;
                  end
               end else if (r_retry < RETRY_MAX) begin
                  r_retry  <= r_retry + 1'b1;
                  r_resend <= 1'b1;
                  r_state  <= S_GAP;
               end else if (r_src == SRC_BOOT) begin
                  r_error   <= 1'b1;
                  r_err_idx <= r_idx;
                  r_state   <= S_FAIL;
               end else begin
                  r_wr_ready <= 1'b1;
                  r_wr_fail  <= 1'b1;
                  r_resend   <= 1'b0;
                  r_state    <= S_GAP;
               end
            end
            S_GAP: begin
               if (r_cnt >= GAP_LAST) begin
                  r_cnt <= '0;
                  if (r_resend) begin
                     r_state <= S_LOAD;
                  end else begin
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            S_IDLE: begin
               if (w_restart) begin
                  r_pend  <= 1'b0;
                  r_done  <= 1'b0;
                  r_error <= 1'b0;
                  r_idx   <= '0;
                  r_retry <= '0;
                  r_src   <= SRC_BOOT;
                  r_state <= S_LOAD;
               end else if (wr_req && r_done) begin
                  r_src   <= SRC_USER;
                  r_retry <= '0;
                  r_state <= S_LOAD;
               end else begin
                  r_busy <= 1'b0;
               end
            end
            S_FAIL: begin
               if (w_restart) begin
                  r_pend  <= 1'b0;
                  r_done  <= 1'b0;
                  r_error <= 1'b0;
                  r_idx   <= '0;
                  r_retry <= '0;
                  r_src   <= SRC_BOOT;
                  r_state <= S_LOAD;
               end
            end
            default: begin
               r_cnt   <= '0;
               r_state <= S_INIT;
            end
         endcase
      end
   end

   assign i2c_start    = r_start;
   assign i2c_data     = r_data;
   assign wr_ready     = r_wr_ready;
   assign wr_fail      = r_wr_fail;
   assign busy         = r_busy;
   assign config_done  = r_done;
   assign config_error = r_error;
   assign err_index    = r_err_idx;

endmodule
